// File: rtl/load_extend_unit.sv
// -----------------------------------------------------------------------------
// load_extend_unit
//
// Load path stage between execute and writeback of the RV64 core. Takes one
// load request at a time, issues an 8-byte-aligned read to data memory,
// extracts the addressed byte/half/word/double lane from the returned data,
// sign- or zero-extends it to XLEN and offers it to writeback.
// Misaligned requests skip memory and complete with out_misalign=1 and
// out_data=0.
//
// Ports:
//   clk, rst           clock (rising edge) and asynchronous active-high reset
//   in_valid/in_ready  request handshake from execute (in_ready only in IDLE)
//   in_addr            byte address of the load
//   in_size            0=byte, 1=half, 2=word, 3=double
//   in_unsigned        1 = zero-extend, 0 = sign-extend
//   mem_req_valid/_ready/_addr   aligned read request to data memory
//   mem_rsp_valid/_data          single-cycle read response, little-endian
//   out_valid/out_ready          result handshake to writeback
//   out_data           extended load result
//   out_misalign       request was misaligned (out_data is 0)
// -----------------------------------------------------------------------------
module load_extend_unit #(
  parameter int XLEN       = 64,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [1:0]            in_size,
  input  logic                  in_unsigned,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_rsp_valid,
  input  logic [XLEN-1:0]       mem_rsp_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_data,
  output logic                  out_misalign
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [2:0]            r_off;
  logic [1:0]            r_size;
  logic                  r_unsigned;
  logic [ADDR_WIDTH-1:0] r_mem_req_addr;
  logic [XLEN-1:0]       r_out_data;
  logic                  r_out_misalign;
  logic                  w_misalign;
  logic [XLEN-1:0]       w_lane;

  // An access is aligned when the low address bits below its size are zero.
  function automatic logic is_misaligned(input logic [2:0] off, input logic [1:0] size);
    logic mis;
    case (size)
      2'd0:    mis = 1'b0;
      2'd1:    mis = off[0];
      2'd2:    mis = |off[1:0];
      2'd3:    mis = |off[2:0];
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Shift the addressed lane down to bit 0, then fill the upper bits with
  // either zeros or the lane MSB. Doubles are always aligned so off is 0.
  function automatic logic [XLEN-1:0] extend_lane(input logic [XLEN-1:0] data,
                                                  input logic [2:0]      off,
                                                  input logic [1:0]      size,
                                                  input logic            uns);
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] res;
    sh = data >> {off, 3'b000};
    case (size)
      2'd0:    res = {{(XLEN-8){sh[7] & ~uns}}, sh[7:0]};
      2'd1:    res = {{(XLEN-16){sh[15] & ~uns}}, sh[15:0]};
      2'd2:    res = {{(XLEN-32){sh[31] & ~uns}}, sh[31:0]};
      2'd3:    res = sh;
      default: res = sh;
    endcase
    return res;
  endfunction

  assign w_misalign = is_misaligned(in_addr[2:0], in_size);
  assign w_lane     = extend_lane(mem_rsp_data, r_off, r_size, r_unsigned);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          if (w_misalign) begin
            w_next_state = S_DONE;
          end else begin
            w_next_state = S_REQ;
          end
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          w_next_state = S_WAIT;
        end else begin
          w_next_state = S_REQ;
        end
      end
      S_WAIT: begin
        if (mem_rsp_valid) begin
          w_next_state = S_DONE;
        end else begin
          w_next_state = S_WAIT;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_DONE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state only.
  always_comb begin
    in_ready      = 1'b0;
    mem_req_valid = 1'b0;
    out_valid     = 1'b0;
    case (r_state)
      S_IDLE:  in_ready      = 1'b1;
      S_REQ:   mem_req_valid = 1'b1;
      S_WAIT:  in_ready      = 1'b0;
      S_DONE:  out_valid     = 1'b1;
      default: in_ready      = 1'b0;
    endcase
  end

  // Request capture and result registers; they only change in IDLE/WAIT, so
  // the request address and the result stay stable under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_off          <= 3'd0;
      r_size         <= 2'd0;
      r_unsigned     <= 1'b0;
      r_mem_req_addr <= {ADDR_WIDTH{1'b0}};
      r_out_data     <= {XLEN{1'b0}};
      r_out_misalign <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_off          <= in_addr[2:0];
            r_size         <= in_size;
            r_unsigned     <= in_unsigned;
            r_mem_req_addr <= {in_addr[ADDR_WIDTH-1:3], 3'b000};
            r_out_misalign <= w_misalign;
            if (w_misalign) begin
              r_out_data <= {XLEN{1'b0}};
            end
          end
        end
        S_WAIT: begin
          if (mem_rsp_valid) begin
            r_out_data <= w_lane;
          end
        end
        default: begin
          r_out_data <= r_out_data;
        end
      endcase
    end
  end

  assign mem_req_addr = r_mem_req_addr;
  assign out_data     = r_out_data;
  assign out_misalign = r_out_misalign;

endmodule

// File: tb/tb_load_extend_unit.sv
// Directed testbench for load_extend_unit. Inputs are driven and outputs
// sampled on the falling clock edge; the unit acts on the rising edge.
module tb_load_extend_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic [1:0]  in_size;
  logic        in_unsigned;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        out_misalign;

  int n_cmp = 0;
  int n_err = 0;
  int n_req = 0;   // accepted memory requests
  int n_reqv = 0;  // cycles with mem_req_valid high

  localparam logic [63:0] D  = 64'h1122_8833_4455_6677;
  localparam logic [63:0] D2 = 64'h0123_4567_89AB_CDEF;

  load_extend_unit #(.XLEN(64), .ADDR_WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_addr      (in_addr),
    .in_size      (in_size),
    .in_unsigned  (in_unsigned),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_addr (mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data (mem_rsp_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_misalign (out_misalign)
  );

  always #5 clk = ~clk;

  // Count memory request traffic seen by the memory side.
  always @(posedge clk) begin
    if (!rst && mem_req_valid) begin
      n_reqv <= n_reqv + 1;
      if (mem_req_ready) n_req <= n_req + 1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Full aligned load with immediate memory and writeback; starts and ends
  // just after a falling edge with the unit idle.
  task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [63:0] data, input logic [63:0] exp_v);
    logic [31:0] a_al;
    a_al = {addr[31:3], 3'b000};
    chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1; in_addr = addr; in_size = size; in_unsigned = uns;
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_req_valid"}, {63'd0, mem_req_valid}, 64'd1);
    chk({tag, "_req_addr"}, {32'd0, mem_req_addr}, {32'd0, a_al});
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    chk({tag, "_wait_out_valid"}, {63'd0, out_valid}, 64'd0);
    mem_rsp_valid = 1'b1; mem_rsp_data = data;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    chk({tag, "_out_valid"}, {63'd0, out_valid}, 64'd1);
    chk({tag, "_out_data"}, out_data, exp_v);
    chk({tag, "_misalign"}, {63'd0, out_misalign}, 64'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_out_valid_clr"}, {63'd0, out_valid}, 64'd0);
    chk({tag, "_in_ready_back"}, {63'd0, in_ready}, 64'd1);
  endtask

  task automatic do_misalign(input string tag, input logic [31:0] addr, input logic [1:0] size);
    int rv0;
    rv0 = n_reqv;
    in_valid = 1'b1; in_addr = addr; in_size = size; in_unsigned = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_out_valid"}, {63'd0, out_valid}, 64'd1);
    chk({tag, "_misalign"}, {63'd0, out_misalign}, 64'd1);
    chk({tag, "_out_data"}, out_data, 64'd0);
    chk({tag, "_req_valid"}, {63'd0, mem_req_valid}, 64'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_out_valid_clr"}, {63'd0, out_valid}, 64'd0);
    chk({tag, "_no_req"}, 64'(n_reqv - rv0), 64'd0);
  endtask

  initial begin
    int n0;
    rst = 1'b0; in_valid = 1'b0; in_addr = 32'd0; in_size = 2'd0; in_unsigned = 1'b0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = 64'd0; out_ready = 1'b0;
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_req_valid", {63'd0, mem_req_valid}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_misalign", {63'd0, out_misalign}, 64'd0);
    chk("rst_req_addr", {32'd0, mem_req_addr}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Lane extraction / extension
    do_load("lb_s5",  32'h8000_0005, 2'd0, 1'b0, D,  64'hFFFF_FFFF_FFFF_FF88);
    do_load("lhu_6",  32'h8000_0006, 2'd1, 1'b1, D,  64'h0000_0000_0000_1122);
    do_load("lw_4",   32'h8000_0004, 2'd2, 1'b0, D,  64'h0000_0000_1122_8833);
    do_load("lbu_5",  32'h8000_0005, 2'd0, 1'b1, D,  64'h0000_0000_0000_0088);
    do_load("lh_s4",  32'h8000_000C, 2'd1, 1'b0, D,  64'hFFFF_FFFF_FFFF_8833);
    do_load("lw_s0",  32'h0000_1000, 2'd2, 1'b0, D2, 64'hFFFF_FFFF_89AB_CDEF);
    do_load("lwu_0",  32'h0000_1000, 2'd2, 1'b1, D2, 64'h0000_0000_89AB_CDEF);
    do_load("lb_0",   32'h0000_1000, 2'd0, 1'b0, D2, 64'hFFFF_FFFF_FFFF_FFEF);
    do_load("ld_0",   32'h0000_1008, 2'd3, 1'b0, D2, D2);

    // Misaligned requests bypass memory
    do_misalign("mis_w3", 32'h8000_0003, 2'd2);
    do_misalign("mis_h1", 32'h8000_0001, 2'd1);
    do_misalign("mis_d4", 32'h8000_0004, 2'd3);
    do_load("after_mis", 32'h8000_0002, 2'd1, 1'b0, D, 64'h0000_0000_0000_4455);

    // Backpressure on both sides; a response while still in REQ is ignored
    n0 = n_req;
    in_valid = 1'b1; in_addr = 32'h8000_0014; in_size = 2'd1; in_unsigned = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_req_valid", {63'd0, mem_req_valid}, 64'd1);
      chk("bp_req_addr", {32'd0, mem_req_addr}, 64'h8000_0010);
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
      mem_rsp_valid = (i == 1);
      mem_rsp_data = D2;
      @(negedge clk);
    end
    mem_rsp_valid = 1'b0;
    chk("bp_req_valid_hold", {63'd0, mem_req_valid}, 64'd1);
    chk("bp_out_valid_req", {63'd0, out_valid}, 64'd0);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    chk("bp_wait_req_valid", {63'd0, mem_req_valid}, 64'd0);
    mem_rsp_valid = 1'b1; mem_rsp_data = D;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_out_data", out_data, 64'hFFFF_FFFF_FFFF_8833);
      chk("bp_in_ready_done", {63'd0, in_ready}, 64'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_out_valid_clr", {63'd0, out_valid}, 64'd0);
    chk("bp_in_ready_back", {63'd0, in_ready}, 64'd1);
    chk("bp_one_request", 64'(n_req - n0), 64'd1);
    chk("bp_data_kept", out_data, 64'hFFFF_FFFF_FFFF_8833);

    // Back-to-back doubles, out_ready and mem_req_ready tied high
    out_ready = 1'b1; mem_req_ready = 1'b1;
    in_valid = 1'b1; in_addr = 32'h0000_0100; in_size = 2'd3; in_unsigned = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b1_req_addr", {32'd0, mem_req_addr}, 64'h0000_0100);
    @(negedge clk);
    mem_rsp_valid = 1'b1; mem_rsp_data = 64'hDEAD_BEEF_0123_4567;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    chk("b2b1_out_valid", {63'd0, out_valid}, 64'd1);
    chk("b2b1_out_data", out_data, 64'hDEAD_BEEF_0123_4567);
    chk("b2b1_in_ready", {63'd0, in_ready}, 64'd0);
    in_valid = 1'b1; in_addr = 32'h0000_0208; in_size = 2'd3; in_unsigned = 1'b0;
    @(negedge clk);
    chk("b2b_gap_in_ready", {63'd0, in_ready}, 64'd1);
    chk("b2b_gap_out_valid", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b2_in_ready", {63'd0, in_ready}, 64'd0);
    chk("b2b2_req_addr", {32'd0, mem_req_addr}, 64'h0000_0208);
    @(negedge clk);
    mem_rsp_valid = 1'b1; mem_rsp_data = 64'h8000_0000_0000_0001;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    chk("b2b2_out_valid", {63'd0, out_valid}, 64'd1);
    chk("b2b2_out_data", out_data, 64'h8000_0000_0000_0001);
    @(negedge clk);
    out_ready = 1'b0; mem_req_ready = 1'b0;
    chk("b2b2_out_valid_clr", {63'd0, out_valid}, 64'd0);

    // Reset while waiting for memory, then a spurious response in IDLE
    in_valid = 1'b1; in_addr = 32'h8000_0020; in_size = 2'd2; in_unsigned = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("arst_req_valid", {63'd0, mem_req_valid}, 64'd0);
    chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_out_data", out_data, 64'd0);
    chk("arst_req_addr", {32'd0, mem_req_addr}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mem_rsp_valid = 1'b1; mem_rsp_data = D;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    chk("spur_out_valid", {63'd0, out_valid}, 64'd0);
    chk("spur_out_data", out_data, 64'd0);
    chk("spur_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    chk("spur_out_valid2", {63'd0, out_valid}, 64'd0);

    do_load("post_rst", 32'h8000_0001, 2'd0, 1'b0, D, 64'h0000_0000_0000_0066);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/load_extend_unit.md
Name: load_extend_unit

Overview:
- Load path stage between the execute stage and writeback in the RV64 core.
- Accepts one load request at a time and issues an 8-byte-aligned read to the data memory port.
- Extracts the addressed byte, half, word or doubleword lane from the returned data.
- Sign- or zero-extends that lane to XLEN and hands the result to writeback over a valid/ready handshake.

Parameters:
- XLEN, 64, width of the returned data and of the memory data bus.
- ADDR_WIDTH, 32, width of the load address.

Ports:
- clk  input  1  clock, all state updates on the rising edge.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  load request from execute is valid.
- in_ready  output  1  unit can accept a request; high only in IDLE.
- in_addr  input  ADDR_WIDTH  byte address of the load.
- in_size  input  2  access size: 0=byte, 1=half, 2=word, 3=double.
- in_unsigned  input  1  1 = zero-extend (LBU/LHU/LWU), 0 = sign-extend.
- mem_req_valid  output  1  read request to memory is valid.
- mem_req_ready  input  1  memory accepts the request.
- mem_req_addr  output  ADDR_WIDTH  request address, with {in_addr[ADDR_WIDTH-1:3],3'b000}.
- mem_rsp_valid  input  1  read data valid; single-cycle pulse.
- mem_rsp_data  input  XLEN  8-byte aligned read data, little-endian.
- out_valid  output  1  result to writeback is valid.
- out_ready  input  1  writeback accepts the result.
- out_data  output  XLEN  extended load result.
- out_misalign  output  1  the request was misaligned; out_data is 0.

Behaviour:
- Reset (async, rst=1):
  - Forces state IDLE.
  - in_ready=1; mem_req_valid=0; out_valid=0; out_data=0; out_misalign=0; mem_req_addr=0.
  - Any request in flight is dropped.
  - Memory responses arriving after rst deasserts while in IDLE are ignored.
- State machine: IDLE, REQ, WAIT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, latch addr, size and unsigned.
  - Misaligned means addr[2:0] is not a multiple of 2^size. Half needs bit0=0; word needs bits[1:0]=0; double needs bits[2:0]=0.
  - If misaligned: go to DONE with out_misalign=1 and out_data=0, and issue no memory request.
  - Otherwise go to REQ.
- REQ:
  - mem_req_valid=1, with mem_req_addr held stable until accepted.
  - On mem_req_ready go to WAIT; otherwise stay in REQ.
- WAIT:
  - On mem_rsp_valid, select the lane.
    - Byte: data[8*off +: 8].
    - Half: data[8*off +: 16].
    - Word: data[8*off +: 32].
    - Double: full XLEN.
    - off = addr[2:0].
  - Extend to XLEN: zero when in_unsigned=1, otherwise replicate the lane MSB.
  - Register the result into out_data and go to DONE.
  - mem_rsp_valid in any state other than WAIT is ignored.
- DONE:
  - out_valid=1; out_data and out_misalign are held stable until handshake.
  - On out_ready, go to IDLE and clear out_valid in the next cycle.
  - out_data keeps its last value after the handshake.
- Size 3 with in_unsigned=1 is legal and identical to signed.
- Latency:
  - Request accepted at cycle N puts mem_req_valid high at N+1.
  - Response at cycle M puts out_valid high at M+1.
  - Misaligned request accepted at N puts out_valid high at N+1.
- Throughput: one outstanding load; a new request is accepted no earlier than the cycle after out handshake.
- mem_req_ready and mem_rsp_valid in the same cycle while in REQ: the response is ignored. Memory must respond after acceptance.
- All outputs are registered or decoded from state only. There are no combinational paths from inputs to outputs, except that in_ready depends on state only.

Test Plan:
- Signed byte load:
  - Stimulus: addr=0x80000005, size=0, unsigned=0; mem_rsp_data=0x1122_8833_4455_6677.
  - Required: mem_req_addr=0x80000000; out_data=0xFFFF_FFFF_FFFF_FF88; out_misalign=0.
- Unsigned half and word loads, same data:
  - Stimulus: addr=...6, size=1, unsigned=1.
  - Required: out_data=0x0000_0000_0000_1122.
  - Stimulus: addr=...4, size=2, unsigned=0.
  - Required: out_data=0x0000_0000_1122_8833.
- Misaligned load:
  - Stimulus: addr=0x80000003, size=2.
  - Required: no mem_req_valid pulse; out_valid at N+1; out_misalign=1; out_data=0.
- Backpressure:
  - Stimulus: mem_req_ready low for 3 cycles; out_ready low for 4 cycles.
  - Required: mem_req_addr and out_data stable throughout; exactly one request issued; in_ready=0 until out handshake.
- Reset mid-operation:
  - Stimulus: assert rst while in WAIT; deassert; then a spurious mem_rsp_valid.
  - Required: outputs go to reset values immediately (asynchronously); state IDLE; spurious response ignored; out_valid stays 0.
- Doubleword back-to-back:
  - Stimulus: two double loads, with out_ready tied high and 1-cycle memory.
  - Required: out_data equals the full mem_rsp_data each time; second in_ready assertion no earlier than the cycle after the first out handshake.
